// File: rtl/mdio_master_ctrl_if.sv
// MDIO master command/response bundle: valid/ready command in, one-cycle response out.
// master: requester side; slave: mdio_master_ctrl side.
interface mdio_master_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  modport master (
    output cmd_valid, cmd_write, cmd_phy_addr,
    output cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_phy_addr,
    input  cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_error, busy
  );
endinterface

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: runs one read/write frame per accepted command.
// Ports: clk, rst_n, bus (cmd/rsp, slave), mdc, mdio_i, mdio_o, mdio_oe.
module mdio_master_ctrl #(
  parameter int MDC_DIV     = 4,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mdio_master_ctrl_if.slave bus,
  output logic              mdc,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe
);
  localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(MDC_DIV - 1);
  localparam logic [5:0] LAST = PREAMBLE_EN ? 6'd63 : 6'd31;
  localparam logic [6:0] OFS  = PREAMBLE_EN ? 7'd0 : 7'd32;

  typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

  state_t        state_q, state_d;
  logic          lead_q, lead_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    slot_q, slot_d;
  logic [63:0]   sr_q, sr_d;
  logic          wr_q, wr_d;
  logic [15:0]   shf_q, shf_d;
  logic          err_q, err_d;
  logic          mdc_d, o_d, oe_d;
  logic          rv_d, rerr_d;
  logic [15:0]   rdata_d;
  logic [1:0]    sync_q;
  logic [63:0]   frm;
  logic [6:0]    cidx, nidx;
  logic          tick, slot_done;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);

  // cidx: frame position of the running slot,
  // nidx: frame position of the slot about to start
  assign cidx = {1'b0, slot_q} + OFS;
  assign nidx = lead_q ? OFS : cidx + 7'd1;
  assign tick = (div_q == DIV_END);
  assign slot_done = (state_q == FRAME) && !lead_q
                   && tick && mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], mdio_i};
  end

  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    div_d   = div_q;
    slot_d  = slot_q;
    sr_d    = sr_q;
    wr_d    = wr_q;
    shf_d   = shf_q;
    err_d   = err_q;
    mdc_d   = mdc;
    o_d     = mdio_o;
    oe_d    = mdio_oe;
    rv_d    = 1'b0;
    rdata_d = bus.rsp_rdata;
    rerr_d  = bus.rsp_error;
    frm = {32'hFFFF_FFFF, 2'b01,
           bus.cmd_write ? 2'b01 : 2'b10,
           bus.cmd_phy_addr, bus.cmd_reg_addr,
           bus.cmd_write ? 2'b10 : 2'b11,
           bus.cmd_write ? bus.cmd_wdata : 16'hFFFF};
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = FRAME;
          lead_d  = 1'b1;
          wr_d    = bus.cmd_write;
          sr_d    = PREAMBLE_EN ? frm
                  : {frm[31:0], 32'hFFFF_FFFF};
          shf_d   = '0;
          err_d   = 1'b0;
          div_d   = '0;
          slot_d  = '0;
        end
      end
      FRAME: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (!lead_q && tick && !mdc) mdc_d = 1'b1;
        // sample on the last clk of the high phase
        if (slot_done) begin
          if (cidx == 7'd47) err_d = sync_q[1];
          if (cidx >= 7'd48)
            shf_d = {shf_q[14:0], sync_q[1]};
        end
        if (slot_done && slot_q == LAST) begin
          state_d = DONE;
          rv_d    = 1'b1;
          mdc_d   = 1'b0;
          oe_d    = 1'b0;
          o_d     = 1'b1;
          rdata_d = wr_q ? 16'h0 : shf_d;
          rerr_d  = wr_q ? 1'b0 : err_d;
        end else if (lead_q || slot_done) begin
          lead_d = 1'b0;
          div_d  = '0;
          mdc_d  = 1'b0;
          slot_d = lead_q ? 6'd0 : slot_q + 6'd1;
          o_d    = sr_q[63];
          sr_d   = {sr_q[62:0], 1'b1};
          // reads release the line from TA onward
          oe_d   = wr_q || (nidx < 7'd46);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lead_q        <= 1'b0;
      div_q         <= '0;
      slot_q        <= '0;
      sr_q          <= '0;
      wr_q          <= 1'b0;
      shf_q         <= '0;
      err_q         <= 1'b0;
      mdc           <= 1'b0;
      mdio_o        <= 1'b1;
      mdio_oe       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      lead_q        <= lead_d;
      div_q         <= div_d;
      slot_q        <= slot_d;
      sr_q          <= sr_d;
      wr_q          <= wr_d;
      shf_q         <= shf_d;
      err_q         <= err_d;
      mdc           <= mdc_d;
      mdio_o        <= o_d;
      mdio_oe       <= oe_d;
      bus.rsp_valid <= rv_d;
      bus.rsp_rdata <= rdata_d;
      bus.rsp_error <= rerr_d;
    end
  end
endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench for mdio_master_ctrl: two instances (preamble/DIV=4, no preamble/DIV=2).
// Frames captured on MDC rising edges; a small PHY model answers reads.
module tb_mdio_master_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  mdio_master_ctrl_if bus1();
  mdio_master_ctrl_if bus2();

  logic mdc1, mdio_o1, mdio_oe1, mdio_i1;
  logic mdc2, mdio_o2, mdio_oe2, mdio_i2;
  logic phy_bit = 1'b1;
  bit   phy_en = 1'b0;
  logic [15:0] phy_data = 16'h0;

  assign mdio_i1 = phy_en ? phy_bit : 1'b1;
  assign mdio_i2 = 1'b1;

  mdio_master_ctrl #(.MDC_DIV(4), .PREAMBLE_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .mdc(mdc1), .mdio_i(mdio_i1),
    .mdio_o(mdio_o1), .mdio_oe(mdio_oe1)
  );

  mdio_master_ctrl #(.MDC_DIV(2), .PREAMBLE_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .mdc(mdc2), .mdio_i(mdio_i2),
    .mdio_o(mdio_o2), .mdio_oe(mdio_oe2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int base = 0;
  int cap_n = 0;
  int cap2_n = 0;
  logic [63:0] cap_o = '0;
  logic [63:0] cap_oe = '0;
  logic [63:0] cap2_o = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus1.rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // PHY answers on MDC rise; master samples at end of high phase
  always @(posedge mdc1) begin
    int k;
    k = cap_n - base;
    cap_o  = {cap_o[62:0], mdio_o1};
    cap_oe = {cap_oe[62:0], mdio_oe1};
    if (k == 47) phy_bit = 1'b0;
    else if (k >= 48 && k <= 63) phy_bit = phy_data[63-k];
    else phy_bit = 1'b1;
    cap_n = cap_n + 1;
  end

  always @(posedge mdc2) begin
    cap2_o = {cap2_o[62:0], mdio_o2};
    cap2_n = cap2_n + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic wr, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd,
                       output int t);
    @(negedge clk);
    bus1.cmd_write    = wr;
    bus1.cmd_phy_addr = pa;
    bus1.cmd_reg_addr = ra;
    bus1.cmd_wdata    = wd;
    bus1.cmd_valid    = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp1(output int t);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t, tr, rc, b2;
    rst_n = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0;
    bus1.cmd_phy_addr = '0; bus1.cmd_reg_addr = '0;
    bus1.cmd_wdata = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0;
    bus2.cmd_phy_addr = '0; bus2.cmd_reg_addr = '0;
    bus2.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus1.cmd_ready, 1);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_pins", {mdc1, mdio_oe1, mdio_o1}, 3'b001);
    chk("rst_rsp", {bus1.rsp_valid, bus1.rsp_error}, 0);
    chk("rst_rdata", bus1.rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write PHY 1 REG 0 A5C3
    base = cap_n;
    send1(1'b1, 5'h01, 5'h00, 16'hA5C3, t);
    chk("wr_busy", bus1.busy, 1);
    wait_rsp1(tr);
    chk("wr_time", tr, t + 513);
    chk("wr_bits", cap_o, 64'hFFFF_FFFF_5082_A5C3);
    chk("wr_oe", cap_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_pulses", cap_n - base, 64);
    chk("wr_err", bus1.rsp_error, 0);
    chk("done_pins", {mdc1, mdio_oe1, mdio_o1}, 3'b001);
    @(negedge clk);
    chk("rsp_one_cycle", bus1.rsp_valid, 0);

    // read with PHY answering 1234
    phy_data = 16'h1234;
    phy_en = 1'b1;
    base = cap_n;
    send1(1'b0, 5'h03, 5'h02, 16'hBEEF, t);
    wait_rsp1(tr);
    phy_en = 1'b0;
    chk("rd_time", tr, t + 513);
    chk("rd_oe", cap_oe, 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_hdr", cap_o >> 18,
        {32'hFFFF_FFFF, 14'b01_10_00011_00010});
    chk("rd_data", bus1.rsp_rdata, 16'h1234);
    chk("rd_err", bus1.rsp_error, 0);

    // read with no PHY
    base = cap_n;
    send1(1'b0, 5'h03, 5'h02, 16'h0, t);
    wait_rsp1(tr);
    chk("nophy_data", bus1.rsp_rdata, 16'hFFFF);
    chk("nophy_err", bus1.rsp_error, 1);

    // back-to-back with valid held and fields changed mid-frame
    base = cap_n;
    @(negedge clk);
    bus1.cmd_write = 1'b1;
    bus1.cmd_phy_addr = 5'h1F;
    bus1.cmd_reg_addr = 5'h1F;
    bus1.cmd_wdata = 16'h0000;
    bus1.cmd_valid = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus1.cmd_phy_addr = 5'h05;
    bus1.cmd_reg_addr = 5'h0A;
    bus1.cmd_wdata = 16'h5A5A;
    chk("b2b_busy_ready", bus1.cmd_ready, 0);
    wait_rsp1(tr);
    chk("b2b_a_time", tr, t + 513);
    chk("b2b_a_bits", cap_o, 64'hFFFF_FFFF_5FFE_0000);
    chk("b2b_a_rdata", bus1.rsp_rdata, 0);
    chk("b2b_a_err", bus1.rsp_error, 0);
    chk("b2b_done_ready", bus1.cmd_ready, 0);
    base = cap_n;
    @(negedge clk);
    chk("b2b_idle_ready", bus1.cmd_ready, 1);
    @(negedge clk);
    chk("b2b_accept", bus1.busy, 1);
    bus1.cmd_valid = 1'b0;
    t = tr + 2;
    wait_rsp1(tr);
    chk("b2b_b_time", tr, t + 513);
    chk("b2b_b_bits", cap_o, 64'hFFFF_FFFF_52AA_5A5A);

    // reset during slot 40 of a write
    base = cap_n;
    send1(1'b1, 5'h01, 5'h00, 16'hA5C3, t);
    for (int i = 0; i < 1000 && (cap_n - base) < 41; i++)
      @(negedge clk);
    chk("rst_at_slot40", cap_n - base, 41);
    rc = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_oe", mdio_oe1, 0);
    chk("abort_mdc", mdc1, 0);
    chk("abort_ready", bus1.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - rc, 0);
    base = cap_n;
    send1(1'b1, 5'h01, 5'h00, 16'hA5C3, t);
    wait_rsp1(tr);
    chk("post_rst_time", tr, t + 513);
    chk("post_rst_bits", cap_o, 64'hFFFF_FFFF_5082_A5C3);

    // no preamble, MDC_DIV=2
    b2 = cap2_n;
    @(negedge clk);
    bus2.cmd_write = 1'b1;
    bus2.cmd_phy_addr = 5'h01;
    bus2.cmd_reg_addr = 5'h00;
    bus2.cmd_wdata = 16'hA5C3;
    bus2.cmd_valid = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    tr = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid === 1'b1) begin
        tr = cyc;
        break;
      end
    end
    chk("np_time", tr, t + 129);
    chk("np_bits", {32'h0, cap2_o[31:0]}, 64'h5082_A5C3);
    chk("np_pulses", cap2_n - b2, 32);
    chk("np_err", bus2.rsp_error, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
